// File: rtl/sqrt_iter_if.sv
// sqrt_iter_if: valid/ready radicand-in and root-out handshake bundle for sqrt_iter.
interface sqrt_iter_if #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 0
);
   localparam int ROOT_W = WIDTH / 2 + FRAC_BITS;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  n;
   logic              out_valid;
   logic              out_ready;
   logic [ROOT_W-1:0] root;
   logic [ROOT_W:0]   rem;
   logic              busy;
   modport master (output in_valid, n, out_ready, input in_ready, out_valid, root, rem, busy);
   modport slave  (input in_valid, n, out_ready, output in_ready, out_valid, root, rem, busy);
endinterface

// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative restoring fixed-point square root, one root bit per clock.
// Define SQRT_ROUND_EN to add a ROUND state that rounds the root to nearest.
module sqrt_iter #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 0
) (
   input logic clk,
   input logic rst_n,
   sqrt_iter_if.slave io
);
   localparam int RW = WIDTH / 2 + FRAC_BITS;
   localparam int CW = $clog2(RW + 1);
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
`ifdef SQRT_ROUND_EN
      ROUND,
`endif
      DONE
   } state_t;
   state_t          state;
   logic [2*RW-1:0] rad;
   logic [RW-1:0]   q;
   logic [RW+1:0]   r, r_sh;
   logic [RW+2:0]   t;
   logic [CW-1:0]   cnt;
   logic            ov, bsy, take;
   // t[RW+2] is the borrow: set means the trial subtraction went negative
   always_comb begin
      r_sh = (r << 2) | {{RW{1'b0}}, rad[2*RW-1 -: 2]};
      t    = {1'b0, r_sh} - {1'b0, q, 2'b01};
   end
   assign io.in_ready  = state == IDLE || (state == DONE && io.out_ready);
   assign take         = io.in_valid && io.in_ready;
   assign io.out_valid = ov;
   assign io.busy      = bsy;
   assign io.root      = q;
   assign io.rem       = r[RW:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         rad   <= '0;
         q     <= '0;
         r     <= '0;
         cnt   <= '0;
         ov    <= 1'b0;
         bsy   <= 1'b0;
      end else if (take) begin
         rad   <= (2*RW)'(io.n) << (2 * FRAC_BITS);
         q     <= '0;
         r     <= '0;
         cnt   <= CW'(RW);
         state <= BUSY;
         ov    <= 1'b0;
         bsy   <= 1'b1;
      end else begin
         case (state)
            BUSY: begin
               rad <= rad << 2;
               r   <= t[RW+2] ? r_sh : t[RW+1:0];
               q   <= {q[RW-2:0], ~t[RW+2]};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
`ifdef SQRT_ROUND_EN
                  state <= ROUND;
`else
                  state <= DONE;
                  ov    <= 1'b1;
`endif
               end
            end
`ifdef SQRT_ROUND_EN
            ROUND: begin
               q     <= (r > {2'b00, q} && !(&q)) ? q + 1'b1 : q;
               state <= DONE;
               ov    <= 1'b1;
            end
`endif
            DONE: if (io.out_ready) begin
               state <= IDLE;
               ov    <= 1'b0;
               bsy   <= 1'b0;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: randomized and directed checks of sqrt_iter against an arithmetic square-root model.
module tb_sqrt_iter;
   localparam int W  = 32;
   localparam int F1 = 8;
`ifdef SQRT_ROUND_EN
   localparam int RX = 1;
`else
   localparam int RX = 0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   sqrt_iter_if #(.WIDTH(W), .FRAC_BITS(0))  a ();
   sqrt_iter_if #(.WIDTH(W), .FRAC_BITS(F1)) b ();
   sqrt_iter #(.WIDTH(W), .FRAC_BITS(0))  u0 (.clk(clk), .rst_n(rst_n), .io(a.slave));
   sqrt_iter #(.WIDTH(W), .FRAC_BITS(F1)) u1 (.clk(clk), .rst_n(rst_n), .io(b.slave));
   int n_tests = 0;
   int n_fail  = 0;
   int pend0 = 0, pend1 = 0, xf0 = 0;
   bit ovq0 = 0, ovq1 = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic longint unsigned isqrt(input longint unsigned v);
      longint unsigned x;
      x = longint'($sqrt(real'(v)));
      while (x * x > v) x--;
      while ((x + 1) * (x + 1) <= v) x++;
      return x;
   endfunction
   // every rising out_valid must be backed by an earlier accepted radicand
   always @(negedge clk) begin
      if (!rst_n) begin
         pend0 = 0;
         pend1 = 0;
      end else begin
         if (a.out_valid && !ovq0) begin
            check("spurious_out0", 64'(pend0 > 0), 1);
            pend0--;
         end
         if (b.out_valid && !ovq1) begin
            check("spurious_out1", 64'(pend1 > 0), 1);
            pend1--;
         end
         if (a.in_valid && a.in_ready) begin
            pend0++;
            xf0++;
         end
         if (b.in_valid && b.in_ready) pend1++;
      end
      ovq0 = a.out_valid;
      ovq1 = b.out_valid;
   end
   task automatic xact(input bit s, input logic [31:0] nv);
      longint unsigned v, er, em, mx;
      int c, rw;
      rw = s ? W / 2 + F1 : W / 2;
      v  = {32'd0, nv};
      v  = v << (s ? 2 * F1 : 0);
      er = isqrt(v);
      em = v - er * er;
      mx = (64'd1 << rw) - 1;
      if (RX == 1 && em > er && er != mx) er++;
      if (s) begin b.in_valid = 1'b1; b.n = nv; end
      else begin a.in_valid = 1'b1; a.n = nv; end
      c = 0;
      while (!(s ? b.in_ready : a.in_ready) && c < 60) begin
         @(posedge clk); #1;
         c++;
      end
      check("accept", 64'(s ? b.in_ready : a.in_ready), 1);
      @(posedge clk); #1;
      if (s) b.in_valid = 1'b0; else a.in_valid = 1'b0;
      c = 0;
      while (!(s ? b.out_valid : a.out_valid) && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("latency", 64'(c), 64'(rw + RX));
      check("root", s ? 64'(b.root) : 64'(a.root), er);
      check("rem", s ? 64'(b.rem) : 64'(a.rem), em);
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: simulation ran past its time limit");
      $fatal(1);
   end
   initial begin
      int xs, c;
      bit seen;
      logic [31:0] k, nv;
      a.in_valid = 0; a.n = '0; a.out_ready = 1;
      b.in_valid = 0; b.n = '0; b.out_ready = 1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(a.out_valid), 0);
      check("rst_busy", 64'(a.busy), 0);
      check("rst_root", 64'(a.root), 0);
      check("rst_rem", 64'(a.rem), 0);
      check("rst_in_ready", 64'(a.in_ready), 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      xact(0, 32'd144);
      xact(0, 32'hFFFF_FFFF);
      xact(0, 32'd0);
      xact(0, 32'd8);
      xact(0, 32'd1);
      xact(0, 32'd3);
      xact(1, 32'd2);
      xact(1, 32'd0);
      xact(1, 32'hFFFF_FFFF);
      xact(1, 32'd8);
      // backpressure: result of 49 held while 81 waits at the input
      a.out_ready = 1'b0;
      xs = xf0;
      xact(0, 32'd49);
      a.in_valid = 1'b1;
      a.n = 32'd81;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_valid", 64'(a.out_valid), 1);
         check("bp_root", 64'(a.root), 7);
         check("bp_rem", 64'(a.rem), 0);
         check("bp_in_ready", 64'(a.in_ready), 0);
      end
      check("bp_xfers", 64'(xf0 - xs), 1);
      a.out_ready = 1'b1;
      #1;
      check("bp_same_edge_ready", 64'(a.in_ready), 1);
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      check("bp_drop_valid", 64'(a.out_valid), 0);
      check("bp_busy", 64'(a.busy), 1);
      c = 0;
      while (!a.out_valid && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("bp_latency", 64'(c), 64'(W / 2 + RX));
      check("bp_root81", 64'(a.root), 9);
      check("bp_rem81", 64'(a.rem), 0);
      // abort a computation partway through
      a.in_valid = 1'b1;
      a.n = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(a.out_valid), 0);
      check("abort_busy", 64'(a.busy), 0);
      check("abort_root", 64'(a.root), 0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_hold_busy", 64'(a.busy), 0);
      check("abort_hold_root", 64'(a.root), 0);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         seen |= a.out_valid;
      end
      check("abort_no_result", 64'(seen), 0);
      xact(0, 32'd25);
      for (int i = 0; i < 2000; i++) begin
         k = $urandom_range(1, 65535);
         case (i % 4)
            0: nv = $urandom;
            1: nv = $urandom_range(0, 1000);
            2: nv = k * k;
            default: nv = k * k - 1;
         endcase
         xact(0, nv);
      end
      for (int i = 0; i < 500; i++) begin
         nv = (i % 2 == 0) ? $urandom : $urandom_range(0, 5000);
         xact(1, nv);
      end
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
